// File: rtl/sayim_birimi_pkg.sv
// Shared constants for the bit-counting unit: opcodes, FSM state encodings, default sizes.
package sayim_birimi_pkg;

    localparam int unsigned VARSAYILAN_VERI_BIT = 32;
    localparam int unsigned VARSAYILAN_ADIM     = 4;

    localparam logic [1:0] OP_CNTP  = 2'd0;
    localparam logic [1:0] OP_CNTZ  = 2'd1;
    localparam logic [1:0] OP_CLZ   = 2'd2;
    localparam logic [1:0] OP_HMDST = 2'd3;

    localparam logic [1:0] BOSTA   = 2'd0;
    localparam logic [1:0] HESAPLA = 2'd1;
    localparam logic [1:0] SONUC   = 2'd2;

endpackage

// File: rtl/sayim_birimi_parca_sayici.sv
// Combinational per-chunk counter: popcount, or trailing/leading zeros gated by the "one seen" flag.
module parca_sayici
    import sayim_birimi_pkg::*;
#(
    parameter int unsigned ADIM = VARSAYILAN_ADIM,
    parameter int unsigned PW   = $clog2(ADIM + 1)
) (
    input  logic [ADIM-1:0] parca,
    input  logic [1:0]      kip,
    input  logic            bir_goruldu,
    output logic [PW-1:0]   sayi,
    output logic            yeni_bir_goruldu
);

    int unsigned bir_sayisi;
    int unsigned sondaki_sifir;
    int unsigned bastaki_sifir;
    logic        bulundu_lsb;
    logic        bulundu_msb;

    always_comb begin
        bir_sayisi    = 0;
        sondaki_sifir = 0;
        bastaki_sifir = 0;
        bulundu_lsb   = 1'b0;
        bulundu_msb   = 1'b0;
        for (int i = 0; i < int'(ADIM); i++) begin
            if (parca[i]) begin
                bir_sayisi = bir_sayisi + 1;
            end
            if (!bulundu_lsb) begin
                if (parca[i]) bulundu_lsb = 1'b1;
                else          sondaki_sifir = sondaki_sifir + 1;
            end
        end
        for (int i = int'(ADIM) - 1; i >= 0; i--) begin
            if (!bulundu_msb) begin
                if (parca[i]) bulundu_msb = 1'b1;
                else          bastaki_sifir = bastaki_sifir + 1;
            end
        end
    end

    always_comb begin
        sayi             = '0;
        yeni_bir_goruldu = bir_goruldu;
        case (kip)
            OP_CNTZ: begin
                // Once a 1 has been seen, later chunks contribute nothing.
                if (!bir_goruldu) begin
                    sayi             = PW'(sondaki_sifir);
                    yeni_bir_goruldu = bulundu_lsb;
                end
            end
            OP_CLZ: begin
                if (!bir_goruldu) begin
                    sayi             = PW'(bastaki_sifir);
                    yeni_bir_goruldu = bulundu_msb;
                end
            end
            default: sayi = PW'(bir_sayisi);
        endcase
    end

endmodule

// File: rtl/sayim_birimi.sv
// Multi-cycle bit counter (CNTP/CNTZ/CLZ/HMDST), ADIM bits per cycle.
// Optional macro SAYIM_ERKEN_BITIR_EN: CNTZ/CLZ finish on the chunk holding the first 1.
module sayim_birimi
    import sayim_birimi_pkg::*;
#(
    parameter int unsigned VERI_BIT = VARSAYILAN_VERI_BIT,
    parameter int unsigned ADIM     = VARSAYILAN_ADIM
) (
    input  logic                clk_i,
    input  logic                rst_i,
    input  logic [1:0]          islem_kod_i,
    input  logic [VERI_BIT-1:0] islem_islec1_i,
    input  logic [VERI_BIT-1:0] islem_islec2_i,
    input  logic                islem_gecerli_i,
    output logic                islem_hazir_o,
    input  logic                iptal_i,
    output logic [VERI_BIT-1:0] sonuc_o,
    output logic                sonuc_gecerli_o,
    input  logic                sonuc_hazir_i
);

    localparam int unsigned N  = VERI_BIT / ADIM;
    localparam int unsigned AW = $clog2(VERI_BIT + 1);
    localparam int unsigned PW = $clog2(ADIM + 1);
    localparam int unsigned CW = (N > 1) ? $clog2(N) : 1;

    if (VERI_BIT % ADIM != 0) begin : g_boyut_hatasi
        $error("sayim_birimi: VERI_BIT must be a multiple of ADIM");
    end

    logic [1:0]          durum_q;
    logic [1:0]          kod_q;
    logic [VERI_BIT-1:0] veri_q;
    logic [AW-1:0]       acc_q;
    logic [CW-1:0]       sayac_q;
    logic                bir_q;

    logic [ADIM-1:0]     parca;
    logic [PW-1:0]       parca_sayi;
    logic                yeni_bir;
    logic                son_parca;

    // CLZ walks MSB-first, everything else LSB-first; the operand register shifts accordingly.
    assign parca = (kod_q == OP_CLZ) ? veri_q[VERI_BIT-1 -: ADIM] : veri_q[ADIM-1:0];

    parca_sayici #(
        .ADIM (ADIM),
        .PW   (PW)
    ) u_parca_sayici (
        .parca            (parca),
        .kip              (kod_q),
        .bir_goruldu      (bir_q),
        .sayi             (parca_sayi),
        .yeni_bir_goruldu (yeni_bir)
    );

`ifdef SAYIM_ERKEN_BITIR_EN
    assign son_parca = (sayac_q == CW'(N - 1)) ||
                       (((kod_q == OP_CNTZ) || (kod_q == OP_CLZ)) && yeni_bir);
`else
    assign son_parca = (sayac_q == CW'(N - 1));
`endif

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            durum_q <= BOSTA;
            kod_q   <= OP_CNTP;
            veri_q  <= '0;
            acc_q   <= '0;
            sayac_q <= '0;
            bir_q   <= 1'b0;
        end else if (iptal_i) begin
            durum_q <= BOSTA;
            acc_q   <= '0;
            sayac_q <= '0;
            bir_q   <= 1'b0;
        end else begin
            case (durum_q)
                BOSTA: begin
                    if (islem_gecerli_i) begin
                        kod_q   <= islem_kod_i;
                        veri_q  <= (islem_kod_i == OP_HMDST) ? (islem_islec1_i ^ islem_islec2_i)
                                                             : islem_islec1_i;
                        acc_q   <= '0;
                        sayac_q <= '0;
                        bir_q   <= 1'b0;
                        durum_q <= HESAPLA;
                    end
                end
                HESAPLA: begin
                    acc_q   <= acc_q + AW'(parca_sayi);
                    bir_q   <= yeni_bir;
                    sayac_q <= sayac_q + 1'b1;
                    veri_q  <= (kod_q == OP_CLZ) ? (veri_q << ADIM) : (veri_q >> ADIM);
                    if (son_parca) begin
                        durum_q <= SONUC;
                    end
                end
                SONUC: begin
                    if (sonuc_hazir_i) begin
                        durum_q <= BOSTA;
                    end
                end
                default: durum_q <= BOSTA;
            endcase
        end
    end

    assign islem_hazir_o   = (durum_q == BOSTA);
    assign sonuc_gecerli_o = (durum_q == SONUC);
    assign sonuc_o         = (durum_q == SONUC) ? VERI_BIT'(acc_q) : '0;

endmodule

// File: tb/tb_sayim_birimi.sv
// Directed-vector bench for sayim_birimi at default sizes; honours SAYIM_ERKEN_BITIR_EN.
module tb_sayim_birimi;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic [1:0]  islem_kod_i;
    logic [31:0] islem_islec1_i;
    logic [31:0] islem_islec2_i;
    logic        islem_gecerli_i;
    logic        islem_hazir_o;
    logic        iptal_i;
    logic [31:0] sonuc_o;
    logic        sonuc_gecerli_o;
    logic        sonuc_hazir_i;

    int vektor = 0;
    int hata   = 0;

    always #5 clk_i = ~clk_i;

    sayim_birimi dut (
        .clk_i           (clk_i),
        .rst_i           (rst_i),
        .islem_kod_i     (islem_kod_i),
        .islem_islec1_i  (islem_islec1_i),
        .islem_islec2_i  (islem_islec2_i),
        .islem_gecerli_i (islem_gecerli_i),
        .islem_hazir_o   (islem_hazir_o),
        .iptal_i         (iptal_i),
        .sonuc_o         (sonuc_o),
        .sonuc_gecerli_o (sonuc_gecerli_o),
        .sonuc_hazir_i   (sonuc_hazir_i)
    );

`ifdef SAYIM_ERKEN_BITIR_EN
    localparam int GEC_CNTZ_10  = 2;
    localparam int GEC_CLZ_1000 = 4;
`else
    localparam int GEC_CNTZ_10  = 8;
    localparam int GEC_CLZ_1000 = 8;
`endif

    // Present a request; returns after the accepting edge (+1).
    task automatic istek(input logic [1:0] kod, input logic [31:0] a, input logic [31:0] b);
        @(negedge clk_i);
        islem_kod_i     = kod;
        islem_islec1_i  = a;
        islem_islec2_i  = b;
        islem_gecerli_i = 1'b1;
        @(posedge clk_i);
        #1;
        islem_gecerli_i = 1'b0;
    endtask

    // Edges from acceptance until sonuc_gecerli_o; -1 if it never comes.
    task automatic bekle(output int gecikme);
        gecikme = -1;
        for (int i = 1; i <= 40; i++) begin
            @(posedge clk_i);
            #1;
            if (sonuc_gecerli_o) begin
                gecikme = i;
                break;
            end
        end
    endtask

    task automatic al();
        @(negedge clk_i);
        sonuc_hazir_i = 1'b1;
        @(posedge clk_i);
        #1;
        sonuc_hazir_i = 1'b0;
    endtask

    task automatic test_reset();
        rst_i = 1'b1;
        #3;
        vektor++;
        if (islem_hazir_o !== 1'b1 || sonuc_gecerli_o !== 1'b0 || sonuc_o !== 32'd0) begin
            hata++;
            $display("FAIL reset: hazir=%b gecerli=%b sonuc=%0d, want 1 0 0",
                     islem_hazir_o, sonuc_gecerli_o, sonuc_o);
        end
        @(negedge clk_i);
        @(negedge clk_i);
        rst_i = 1'b0;
    endtask

    task automatic calistir(input string ad, input logic [1:0] kod, input logic [31:0] a,
                            input logic [31:0] b, input int beklenen, input int gec_beklenen);
        int g;
        istek(kod, a, b);
        vektor++;
        if (islem_hazir_o !== 1'b0) begin
            hata++;
            $display("FAIL %s busy: hazir=%b, want 0", ad, islem_hazir_o);
        end
        bekle(g);
        vektor++;
        if (g != gec_beklenen) begin
            hata++;
            $display("FAIL %s latency: got %0d, want %0d", ad, g, gec_beklenen);
        end
        vektor++;
        if (sonuc_o !== 32'(beklenen)) begin
            hata++;
            $display("FAIL %s result: got %0d, want %0d", ad, sonuc_o, beklenen);
        end
        al();
        vektor++;
        if (islem_hazir_o !== 1'b1 || sonuc_gecerli_o !== 1'b0) begin
            hata++;
            $display("FAIL %s release: hazir=%b gecerli=%b, want 1 0",
                     ad, islem_hazir_o, sonuc_gecerli_o);
        end
    endtask

    task automatic test_cntp();
        calistir("cntp", 2'd0, 32'hF0F0_000F, 32'h0, 12, 8);
    endtask

    task automatic test_cntz();
        calistir("cntz_10", 2'd1, 32'h0000_0010, 32'h0, 4, GEC_CNTZ_10);
        calistir("cntz_0", 2'd1, 32'h0, 32'h0, 32, 8);
    endtask

    task automatic test_clz();
        calistir("clz_0", 2'd2, 32'h0, 32'h0, 32, 8);
        calistir("clz_10000", 2'd2, 32'h0001_0000, 32'h0, 15, GEC_CLZ_1000);
    endtask

    task automatic test_hmdst();
        calistir("hmdst_diff", 2'd3, 32'hFFFF_0000, 32'h0000_FFFF, 32, 8);
        calistir("hmdst_eq", 2'd3, 32'h1234_5678, 32'h1234_5678, 0, 8);
    endtask

    // Hold the result, then release with a new request already pending.
    task automatic test_back_to_back();
        int g;
        istek(2'd0, 32'h0000_00FF, 32'h0);
        bekle(g);
        vektor++;
        if (g != 8 || sonuc_o !== 32'd8) begin
            hata++;
            $display("FAIL hold_setup: latency %0d result %0d, want 8 8", g, sonuc_o);
        end
        @(negedge clk_i);
        islem_islec1_i = 32'hFFFF_FFFF;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk_i);
            #1;
            vektor++;
            if (sonuc_o !== 32'd8 || sonuc_gecerli_o !== 1'b1 || islem_hazir_o !== 1'b0) begin
                hata++;
                $display("FAIL hold%0d: sonuc=%0d gecerli=%b hazir=%b, want 8 1 0",
                         i, sonuc_o, sonuc_gecerli_o, islem_hazir_o);
            end
        end
        @(negedge clk_i);
        sonuc_hazir_i   = 1'b1;
        islem_kod_i     = 2'd0;
        islem_islec1_i  = 32'h0000_0007;
        islem_gecerli_i = 1'b1;
        @(posedge clk_i);
        #1;
        sonuc_hazir_i = 1'b0;
        vektor++;
        if (islem_hazir_o !== 1'b1) begin
            hata++;
            $display("FAIL release_no_accept: hazir=%b, want 1", islem_hazir_o);
        end
        @(posedge clk_i);
        #1;
        islem_gecerli_i = 1'b0;
        vektor++;
        if (islem_hazir_o !== 1'b0) begin
            hata++;
            $display("FAIL next_accept: hazir=%b, want 0", islem_hazir_o);
        end
        bekle(g);
        vektor++;
        if (g != 8 || sonuc_o !== 32'd3) begin
            hata++;
            $display("FAIL b2b_result: latency %0d result %0d, want 8 3", g, sonuc_o);
        end
        al();
    endtask

    task automatic sessiz_mi(input string ad);
        logic goruldu = 1'b0;
        for (int i = 0; i < 12; i++) begin
            @(posedge clk_i);
            #1;
            if (sonuc_gecerli_o) goruldu = 1'b1;
        end
        vektor++;
        if (goruldu) begin
            hata++;
            $display("FAIL %s no_result: gecerli seen=1, want 0", ad);
        end
    endtask

    task automatic test_abort();
        istek(2'd0, 32'hFFFF_FFFF, 32'h0);
        @(posedge clk_i);
        @(posedge clk_i);
        @(negedge clk_i);
        iptal_i = 1'b1;
        @(posedge clk_i);
        #1;
        iptal_i = 1'b0;
        vektor++;
        if (islem_hazir_o !== 1'b1 || sonuc_gecerli_o !== 1'b0 || sonuc_o !== 32'd0) begin
            hata++;
            $display("FAIL abort: hazir=%b gecerli=%b sonuc=%0d, want 1 0 0",
                     islem_hazir_o, sonuc_gecerli_o, sonuc_o);
        end
        sessiz_mi("abort");
        calistir("after_abort", 2'd0, 32'hF0F0_000F, 32'h0, 12, 8);
    endtask

    task automatic test_reset_mid();
        istek(2'd3, 32'hFFFF_0000, 32'h0000_FFFF);
        @(posedge clk_i);
        @(posedge clk_i);
        @(negedge clk_i);
        rst_i = 1'b1;
        #1;
        vektor++;
        if (islem_hazir_o !== 1'b1 || sonuc_gecerli_o !== 1'b0 || sonuc_o !== 32'd0) begin
            hata++;
            $display("FAIL reset_mid: hazir=%b gecerli=%b sonuc=%0d, want 1 0 0",
                     islem_hazir_o, sonuc_gecerli_o, sonuc_o);
        end
        @(negedge clk_i);
        rst_i = 1'b0;
        sessiz_mi("reset_mid");
        calistir("after_reset", 2'd2, 32'h0001_0000, 32'h0, 15, GEC_CLZ_1000);
    endtask

    initial begin
        islem_kod_i     = 2'd0;
        islem_islec1_i  = 32'h0;
        islem_islec2_i  = 32'h0;
        islem_gecerli_i = 1'b0;
        iptal_i         = 1'b0;
        sonuc_hazir_i   = 1'b0;
        test_reset();
        test_cntp();
        test_cntz();
        test_clz();
        test_hmdst();
        test_back_to_back();
        test_abort();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", vektor, hata);
        $finish;
    end

endmodule

// File: doc/sayim_birimi.md
SAYIM_BIRIMI -- requirements
Module: sayim_birimi

Interface
REQ-001 SHALL have parameter VERI_BIT, default 32, giving the operand and result width.
REQ-002 SHALL have parameter ADIM, default 4, giving the number of bits examined per cycle.
REQ-003 SHALL have port clk_i  input  1  the single clock; all state changes on its rising edge.
REQ-004 SHALL have port rst_i  input  1  reset, asynchronous and active-high.
REQ-005 SHALL have port islem_kod_i  input  2  operation select: 0 CNTP (popcount), 1 CNTZ (trailing zeros), 2 CLZ (leading zeros), 3 HMDST (Hamming distance).
REQ-006 SHALL have port islem_islec1_i  input  VERI_BIT  first operand.
REQ-007 SHALL have port islem_islec2_i  input  VERI_BIT  second operand, used only by HMDST.
REQ-008 SHALL have port islem_gecerli_i  input  1  request valid.
REQ-009 SHALL have port islem_hazir_o  output  1  unit can accept a request.
REQ-010 SHALL have port iptal_i  input  1  abort of the current operation.
REQ-011 SHALL have port sonuc_o  output  VERI_BIT  count result, zero-extended.
REQ-012 SHALL have port sonuc_gecerli_o  output  1  result valid.
REQ-013 SHALL have port sonuc_hazir_i  input  1  consumer accepts the result.

Function
REQ-014 SHALL have an FSM with states BOSTA, HESAPLA and SONUC; islem_hazir_o is 1 only in BOSTA, and sonuc_gecerli_o is 1 only in SONUC.
REQ-015 SHALL accept a request on an edge where the state is BOSTA and islem_gecerli_i=1, latching the opcode and the operands (HMDST latches islec1^islec2), clearing the accumulator and chunk counter, and entering HESAPLA.
REQ-016 SHALL process one ADIM-bit chunk per HESAPLA cycle, with N=VERI_BIT/ADIM chunks in total.
- CNTP/HMDST/CNTZ: chunks taken LSB-first.
- CLZ: chunks taken MSB-first.
REQ-017 SHALL, for CNTZ/CLZ, keep a "one seen" flag: after the first 1 is found, the zeros before it in that chunk are added and all later chunks add 0.
REQ-018 SHALL go from HESAPLA to SONUC on the edge that processes chunk N-1, so sonuc_gecerli_o rises exactly N cycles after the accepting edge (8 cycles at the defaults).
REQ-019 SHALL keep sonuc_o stable in SONUC and hold it until sonuc_hazir_i=1, then return to BOSTA on that edge; no new request is accepted in that same cycle.
REQ-020 SHALL produce VERI_BIT for CNTZ/CLZ when the operand is zero, and 0 for HMDST when the two operands are equal.
REQ-021 SHALL treat iptal_i=1 as highest priority: from any state, go to BOSTA on the next edge with no result produced and sonuc_o cleared to 0.
REQ-022 SHALL use an accumulator of clog2(VERI_BIT+1) bits, zero-extended onto sonuc_o; sonuc_o is 0 outside SONUC.
REQ-023 SHALL ignore islem_gecerli_i and input changes outside BOSTA.

Reset
REQ-024 SHALL, while rst_i=1, immediately force the state to BOSTA and the accumulator, counter and flags to 0.
- Outputs during reset: islem_hazir_o=1, sonuc_gecerli_o=0, sonuc_o=0.
REQ-025 SHALL, on reset asserted mid-operation, discard that operation with no result ever presented.

Configuration
REQ-026 SHALL support macro SAYIM_ERKEN_BITIR_EN.
- Defined: CNTZ/CLZ enter SONUC on the edge that processes the chunk containing the first 1 (latency = chunk index + 1); CNTP/HMDST are unchanged.
- Undefined: every opcode takes exactly N cycles.

Structure
REQ-027 SHALL place the opcode constants, the FSM state encodings and the default VERI_BIT/ADIM values in the shared package.
REQ-028 SHALL use one combinational sub-module, parca_sayici.
- Inputs: one ADIM-bit chunk, the mode and the "one seen" flag.
- Outputs: the chunk count and the updated flag.
REQ-029 SHALL stop elaboration with an error when VERI_BIT is not a multiple of ADIM.

Verification
REQ-030 SHALL check CNTP with islec1=0xF0F0_000F at the defaults: sonuc_o=12, with sonuc_gecerli_o high 8 cycles after acceptance.
REQ-031 SHALL check CNTZ with islec1=0x0000_0010: result 4.
- Macro defined: valid after 2 cycles.
- Macro undefined: valid after 8 cycles.
REQ-032 SHALL check CLZ and CNTZ with islec1=0: result 32; and CLZ with 0x0001_0000: result 15.
REQ-033 SHALL check HMDST with 0xFFFF_0000 vs 0x0000_FFFF: result 32; and equal operands: result 0.
REQ-034 SHALL check that holding sonuc_hazir_i=0 for 5 cycles keeps the result stable and islem_hazir_o=0, and that releasing it returns the unit to BOSTA.
REQ-035 SHALL check abort and reset at cycle 3 of HESAPLA.
- iptal_i=1 at cycle 3: BOSTA on the next edge, no sonuc_gecerli_o, and the next request computes correctly.
- rst_i asserted at cycle 3: outputs return to their reset values with no result.
